// File: rtl/seg_digit_loader.sv
// ---------------------------------------------------------------------------
// seg_digit_loader
//   Converts an ASCII byte stream from the UART receiver into six committed
//   display digits. Hex characters are shifted into an edit buffer, '.' sets
//   the decimal point of the newest digit, and CR copies the edit buffer to
//   the shown digits. ESC clears the edit buffer. Any unrecognised byte
//   starts a hold timer that keeps err high.
//
// Parameters
//   ERR_HOLD   cycles err stays high after the last illegal byte (>= 1)
//   ERR_W      width of the error timer (must hold ERR_HOLD)
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   rx_data     in   received byte
//   rx_valid    in   rx_data valid (transfer when rx_valid && rx_ready)
//   rx_ready    out  loader accepts a byte this cycle
//   dig0..dig5  out  committed digits, [4]=dp, [3:0]=hex; dig0 rightmost
//   err         out  illegal byte seen within the last ERR_HOLD cycles
//   commit_cnt  out  number of commits since reset, wraps
// ---------------------------------------------------------------------------
module seg_digit_loader #(
    parameter int ERR_HOLD = 50_000_000,
    parameter int ERR_W    = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [4:0] dig0,
    output logic [4:0] dig1,
    output logic [4:0] dig2,
    output logic [4:0] dig3,
    output logic [4:0] dig4,
    output logic [4:0] dig5,
    output logic       err,
    output logic [7:0] commit_cnt
);

    localparam logic [ERR_W-1:0] ERR_LOAD = ERR_W'(ERR_HOLD);

    localparam logic [7:0] CH_CR  = 8'h0D;
    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_ESC = 8'h1B;
    localparam logic [7:0] CH_DOT = 8'h2E;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECODE,
        ST_COMMIT
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_rx_ready;
    logic [7:0]       r_byte;
    logic [5:0][4:0]  r_edit;
    logic [5:0][4:0]  r_shown;
    logic [2:0]       r_cnt;
    logic [7:0]       r_commit_cnt;
    logic [ERR_W-1:0] r_timer;

    logic             w_take;
    logic             w_is_hex;
    logic             w_illegal;
    logic [3:0]       w_nibble;

    function automatic logic is_hex(input logic [7:0] b);
        return ((b >= 8'h30) && (b <= 8'h39)) ||
               ((b >= 8'h41) && (b <= 8'h46)) ||
               ((b >= 8'h61) && (b <= 8'h66));
    endfunction

    // 'A'..'F' and 'a'..'f' both carry 1..6 in their low nibble.
    function automatic logic [3:0] hex_nibble(input logic [7:0] b);
        if (b[6]) begin
            return b[3:0] + 4'd9;
        end
        return b[3:0];
    endfunction

    assign w_take    = (r_state == ST_IDLE) && rx_valid && r_rx_ready;
    assign w_is_hex  = is_hex(r_byte);
    assign w_nibble  = hex_nibble(r_byte);
    assign w_illegal = (r_state == ST_DECODE) && !w_is_hex &&
                       (r_byte != CH_DOT) && (r_byte != CH_CR) &&
                       (r_byte != CH_LF) && (r_byte != CH_ESC);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_take) begin
                    w_state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (r_byte == CH_CR) begin
                    w_state_nxt = ST_COMMIT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_COMMIT: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_rx_ready <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            // Registered so ready stays low in the cycle right after reset.
            r_rx_ready <= (w_state_nxt == ST_IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte       <= '0;
            r_edit       <= '0;
            r_shown      <= '0;
            r_cnt        <= '0;
            r_commit_cnt <= '0;
        end else begin
            if (w_take) begin
                r_byte <= rx_data;
            end
            if (r_state == ST_DECODE) begin
                if (w_is_hex) begin
                    r_edit <= {r_edit[4:0], {1'b0, w_nibble}};
                    if (r_cnt != 3'd6) begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end else if (r_byte == CH_DOT) begin
                    if (r_cnt != 3'd0) begin
                        r_edit[0][4] <= 1'b1;
                    end
                end else if (r_byte == CH_ESC) begin
                    r_edit <= '0;
                    r_cnt  <= '0;
                end
            end
            if (r_state == ST_COMMIT) begin
                r_shown      <= r_edit;
                r_edit       <= '0;
                r_cnt        <= '0;
                r_commit_cnt <= r_commit_cnt + 8'd1;
            end
        end
    end

    // A new illegal byte reloads the timer even while it is still running.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer <= '0;
        end else if (w_illegal) begin
            r_timer <= ERR_LOAD;
        end else if (r_timer != '0) begin
            r_timer <= r_timer - ERR_W'(1);
        end
    end

    assign rx_ready   = r_rx_ready;
    assign err        = (r_timer != '0);
    assign commit_cnt = r_commit_cnt;
    assign dig0       = r_shown[0];
    assign dig1       = r_shown[1];
    assign dig2       = r_shown[2];
    assign dig3       = r_shown[3];
    assign dig4       = r_shown[4];
    assign dig5       = r_shown[5];

endmodule

// File: tb/tb_seg_digit_loader.sv
// ---------------------------------------------------------------------------
// tb_seg_digit_loader
//   Directed bench for seg_digit_loader with ERR_HOLD=8.
// ---------------------------------------------------------------------------
module tb_seg_digit_loader;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [4:0] dig0, dig1, dig2, dig3, dig4, dig5;
    logic       err;
    logic [7:0] commit_cnt;
    logic [29:0] digs;

    int total = 0;
    int bad   = 0;
    int w;
    int n;

    seg_digit_loader #(
        .ERR_HOLD(8),
        .ERR_W   (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .dig0      (dig0),
        .dig1      (dig1),
        .dig2      (dig2),
        .dig3      (dig3),
        .dig4      (dig4),
        .dig5      (dig5),
        .err       (err),
        .commit_cnt(commit_cnt)
    );

    assign digs = {dig5, dig4, dig3, dig2, dig1, dig0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents a byte, waits (bounded) for ready, handshakes at the next edge.
    // Returns #1 after the handshake edge. waits = cycles spent with ready low.
    task automatic send_byte(input logic [7:0] b, input bit keep, output int waits);
        rx_data  = b;
        rx_valid = 1'b1;
        waits    = 0;
        while (!rx_ready && waits < 20) begin
            tick();
            waits++;
        end
        chk("handshake_ready", {31'd0, rx_ready}, 32'd1);
        tick();
        if (!keep) rx_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        int wd;
        send_byte(b, 1'b0, wd);
    endtask

    task automatic send_commit();
        send(8'h0D);
        tick();
        tick();
    endtask

    // Counts consecutive cycles with err high, bounded.
    task automatic err_run(output int cnt);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (err) cnt++;
            else break;
        end
    endtask

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        // ---- 1: reset state, basic commit and CR timing
        tick();
        tick();
        chk("rst_digs",  {2'b0, digs}, 32'd0);
        chk("rst_ready", {31'd0, rx_ready}, 32'd0);
        chk("rst_err",   {31'd0, err}, 32'd0);
        chk("rst_cc",    {24'd0, commit_cnt}, 32'd0);
        rst = 1'b0;
        tick();
        chk("ready_after_rst", {31'd0, rx_ready}, 32'd1);
        send("1"); send("2"); send("A"); send("B"); send("3"); send("F");
        send(8'h0D);
        chk("cr_k_digs", {2'b0, digs}, 32'd0);
        tick();
        chk("cr_k1_digs",  {2'b0, digs}, 32'd0);
        chk("cr_k1_cc",    {24'd0, commit_cnt}, 32'd0);
        chk("cr_k1_ready", {31'd0, rx_ready}, 32'd0);
        tick();
        chk("t1_digs", {2'b0, digs},
            {2'b0, 5'h01, 5'h02, 5'h0A, 5'h0B, 5'h03, 5'h0F});
        chk("t1_cc",    {24'd0, commit_cnt}, 32'd1);
        chk("t1_ready", {31'd0, rx_ready}, 32'd1);

        // ---- 2: decimal point, empty commit
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        send("7"); send("."); send("5");
        send_commit();
        chk("t2_dp_digs", {2'b0, digs}, {2'b0, 5'h00, 5'h00, 5'h00, 5'h00, 5'h17, 5'h05});
        send("."); send(".");
        send_commit();
        chk("t2_empty_digs", {2'b0, digs}, 32'd0);
        chk("t2_err", {31'd0, err}, 32'd0);
        chk("t2_cc", {24'd0, commit_cnt}, 32'd2);

        // ---- 3: overflow drops oldest, ESC clears, lower case hex
        send("1"); send("2"); send("3"); send("4"); send("5"); send("6"); send("7");
        send_commit();
        chk("t3_ovf_digs", {2'b0, digs},
            {2'b0, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07});
        send("9"); send(8'h1B);
        send_commit();
        chk("t3_esc_digs", {2'b0, digs}, 32'd0);
        chk("t3_cc", {24'd0, commit_cnt}, 32'd4);
        send("a"); send("f"); send("."); send("c"); send("E");
        send_commit();
        chk("t3_lc_digs", {2'b0, digs},
            {2'b0, 5'h00, 5'h00, 5'h0A, 5'h1F, 5'h0C, 5'h0E});
        chk("t3_lc_err", {31'd0, err}, 32'd0);

        // ---- 4: error timer
        send("4");
        send(8'h0A);
        tick();
        tick();
        chk("t4_lf_noerr", {31'd0, err}, 32'd0);
        send("G");
        chk("t4_err_not_yet", {31'd0, err}, 32'd0);
        err_run(n);
        chk("t4_hold_len", n, 32'd8);
        chk("t4_err_cleared", {31'd0, err}, 32'd0);
        send("G");
        tick(); tick(); tick(); tick();
        chk("t4_err_mid", {31'd0, err}, 32'd1);
        send("x");
        err_run(n);
        chk("t4_reload_len", n, 32'd8);
        send_commit();
        chk("t4_buf_intact", {2'b0, digs}, 32'd4);
        send(8'hB1);
        tick();
        chk("t4_bit7_err", {31'd0, err}, 32'd1);
        send_commit();
        chk("t4_bit7_digs", {2'b0, digs}, 32'd0);
        chk("t4_cc", {24'd0, commit_cnt}, 32'd7);

        // ---- 5: rx_valid held high, back-to-back bytes
        send_byte("A", 1'b1, w);
        chk("t5_ready_low0", {31'd0, rx_ready}, 32'd0);
        send_byte("B", 1'b1, w);
        chk("t5_wait1", w, 32'd1);
        chk("t5_ready_low1", {31'd0, rx_ready}, 32'd0);
        send_byte("C", 1'b1, w);
        chk("t5_wait2", w, 32'd1);
        send_byte("D", 1'b1, w);
        chk("t5_wait3", w, 32'd1);
        send_byte("E", 1'b1, w);
        chk("t5_wait4", w, 32'd1);
        send_byte(8'h0D, 1'b1, w);
        chk("t5_wait5", w, 32'd1);
        send_byte("1", 1'b0, w);
        chk("t5_wait_cr", w, 32'd2);
        chk("t5_digs", {2'b0, digs},
            {2'b0, 5'h00, 5'h0A, 5'h0B, 5'h0C, 5'h0D, 5'h0E});
        chk("t5_cc", {24'd0, commit_cnt}, 32'd8);
        send_commit();
        chk("t5_after_digs", {2'b0, digs}, 32'd1);

        // ---- 6: reset in DECODE and in COMMIT
        send("Z");
        send("5");
        chk("t6_err_before", {31'd0, err}, 32'd1);
        rst = 1'b1;
        tick();
        chk("t6_dec_digs",  {2'b0, digs}, 32'd0);
        chk("t6_dec_err",   {31'd0, err}, 32'd0);
        chk("t6_dec_cc",    {24'd0, commit_cnt}, 32'd0);
        chk("t6_dec_ready", {31'd0, rx_ready}, 32'd0);
        rst = 1'b0;
        tick();
        chk("t6_dec_ready_up", {31'd0, rx_ready}, 32'd1);
        send("3");
        send_commit();
        chk("t6_commit3", {2'b0, digs}, 32'd3);
        send("8");
        send(8'h0D);
        tick();
        rst = 1'b1;
        tick();
        chk("t6_com_digs",  {2'b0, digs}, 32'd0);
        chk("t6_com_cc",    {24'd0, commit_cnt}, 32'd0);
        chk("t6_com_ready", {31'd0, rx_ready}, 32'd0);
        rst = 1'b0;
        tick();
        chk("t6_com_ready_up", {31'd0, rx_ready}, 32'd1);
        send_commit();
        chk("t6_discard_digs", {2'b0, digs}, 32'd0);
        chk("t6_discard_cc", {24'd0, commit_cnt}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
